// File: rtl/fetch_queue_stage.sv
// Prefetching fetch stage: fills a circular byte queue from instruction memory,
// length-decodes the head opcode and issues one whole instruction per handshake.
module fetch_queue_stage #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       FETCH_BYTES = 4,
    parameter int unsigned       QDEPTH      = 16,
    parameter int unsigned       MAX_ILEN    = 5,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [8*FETCH_BYTES-1:0] imem_data,
    input  logic                     imem_valid,
    input  logic                     is_jmp,
    input  logic [ADDR_W-1:0]        jmp_target,
    input  logic                     is_halt,
    output logic [8*MAX_ILEN-1:0]    instr,
    output logic [2:0]               instr_len,
    output logic [ADDR_W-1:0]        instr_pc,
    output logic [ADDR_W-1:0]        next_pc,
    output logic                     instr_illegal,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic                     halted
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_head_pc;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_inflight;
    logic [7:0]        r_queue [QDEPTH];

    logic [PTR_W-1:0]  w_rd_idx [MAX_ILEN];
    logic [7:0]        w_byte   [MAX_ILEN];
    logic [PTR_W-1:0]  w_wr_idx [FETCH_BYTES];
    logic [2:0]        w_len;
    logic              w_known;
    logic              w_has_head;
    logic              w_valid;
    logic              w_fire;
    logic              w_wr;
    logic              w_req;
    logic [CNT_W:0]    w_used;
    logic [CNT_W-1:0]  w_count_next;
    logic [ADDR_W-1:0] w_next_pc;

    // Bytes beyond the occupied count read as zero, so stale storage never leaks out.
    for (genvar i = 0; i < MAX_ILEN; i++) begin : g_rd
        assign w_rd_idx[i]     = r_head + PTR_W'(i);
        assign w_byte[i]       = (CNT_W'(i) < r_count) ? r_queue[w_rd_idx[i]] : 8'h00;
        assign instr[8*i +: 8] = (3'(i) < w_len) ? w_byte[i] : 8'h00;
    end

    for (genvar k = 0; k < FETCH_BYTES; k++) begin : g_wr
        assign w_wr_idx[k] = r_tail + PTR_W'(k);
    end

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_len   = 3'd1;
        w_known = 1'b1;
        case (w_byte[0]) inside
            8'h90, 8'hF4:         w_len = 3'd1;
            8'h01:                w_len = 3'd2;
            8'h83:                w_len = 3'd3;
            [8'hB8:8'hBF], 8'hE9: w_len = 3'd5;
            default:              w_known = 1'b0;
        endcase
    end

    assign w_has_head = (r_count != '0);
    assign w_valid    = (r_state == ST_RUN) && w_has_head && (r_count >= CNT_W'(w_len));
    assign w_fire     = w_valid && instr_ready;
    assign w_wr       = imem_valid && r_inflight;

    // Space left after counting the bytes already promised by an outstanding request.
    assign w_used = {1'b0, r_count} + (r_inflight ? (CNT_W+1)'(FETCH_BYTES) : '0);
    assign w_req  = rst_n && (r_state == ST_RUN) && !is_jmp
                    && (w_used <= (CNT_W+1)'(QDEPTH - FETCH_BYTES));

    assign w_count_next = r_count + (w_wr ? CNT_W'(FETCH_BYTES) : '0)
                                  - (w_fire ? CNT_W'(w_len) : '0);
    // An empty queue reports next_pc equal to instr_pc.
    assign w_next_pc    = r_head_pc + (w_has_head ? ADDR_W'(w_len) : '0);

    // NOTE: nonblocking assignments for all clocked state, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_fetch_pc <= RESET_PC;
            r_head_pc  <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
        end else if (is_jmp) begin
            r_state    <= ST_RUN;
            r_fetch_pc <= jmp_target;
            r_head_pc  <= jmp_target;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_req;
            r_count    <= w_count_next;
            if (w_req) r_fetch_pc <= r_fetch_pc + ADDR_W'(FETCH_BYTES);
            if (w_wr)  r_tail     <= r_tail + PTR_W'(FETCH_BYTES);
            if (w_fire) begin
                r_head    <= r_head + PTR_W'(w_len);
                r_head_pc <= w_next_pc;
            end
            if ((w_fire && w_byte[0] == 8'hF4) || is_halt) r_state <= ST_HALTED;
        end
    end

    // NOTE: queue storage has no reset; the count alone decides which bytes are meaningful.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int k = 0; k < FETCH_BYTES; k++) r_queue[w_wr_idx[k]] <= imem_data[8*k +: 8];
        end
    end

    assign imem_req      = w_req;
    assign imem_addr     = r_fetch_pc;
    assign instr_len     = w_len;
    assign instr_pc      = r_head_pc;
    assign next_pc       = w_next_pc;
    assign instr_illegal = w_has_head && !w_known;
    assign instr_valid   = w_valid;
    assign halted        = (r_state == ST_HALTED);

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: a 16-byte queue instance for streaming,
// backpressure, halt, jump and reset, plus an 8-byte instance for queue wrap.
module tb_fetch_queue_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- main instance (QDEPTH=16) ----------------
    logic        rst_n, a_req, a_valid, is_jmp, is_halt, a_ivalid, a_ready, a_ill, a_halted;
    logic [31:0] a_addr, jmp_target, a_pc, a_npc;
    logic [31:0] a_data;
    logic [39:0] a_instr;
    logic [2:0]  a_len;
    logic [7:0]  mem_a [256];

    fetch_queue_stage #(.ADDR_W(32), .FETCH_BYTES(4), .QDEPTH(16), .MAX_ILEN(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .imem_req(a_req), .imem_addr(a_addr), .imem_data(a_data),
        .imem_valid(a_valid), .is_jmp(is_jmp), .jmp_target(jmp_target), .is_halt(is_halt),
        .instr(a_instr), .instr_len(a_len), .instr_pc(a_pc), .next_pc(a_npc),
        .instr_illegal(a_ill), .instr_valid(a_ivalid), .instr_ready(a_ready), .halted(a_halted)
    );

    // ---------------- wrap instance (QDEPTH=8) ----------------
    logic        b_rst_n, b_req, b_valid, b_jmp, b_halt, b_ivalid, b_ready, b_ill, b_halted;
    logic [31:0] b_addr, b_target, b_pc, b_npc;
    logic [31:0] b_data;
    logic [39:0] b_instr;
    logic [2:0]  b_len;
    logic [7:0]  mem_b [256];

    fetch_queue_stage #(.ADDR_W(32), .FETCH_BYTES(4), .QDEPTH(8), .MAX_ILEN(5)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .imem_req(b_req), .imem_addr(b_addr), .imem_data(b_data),
        .imem_valid(b_valid), .is_jmp(b_jmp), .jmp_target(b_target), .is_halt(b_halt),
        .instr(b_instr), .instr_len(b_len), .instr_pc(b_pc), .next_pc(b_npc),
        .instr_illegal(b_ill), .instr_valid(b_ivalid), .instr_ready(b_ready), .halted(b_halted)
    );

    // Memory models: respond exactly one cycle after each request.
    always @(posedge clk) begin
        a_valid <= a_req;
        for (int k = 0; k < 4; k++) a_data[8*k +: 8] <= mem_a[a_addr[7:0] + 8'(k)];
    end
    always @(posedge clk) begin
        b_valid <= b_req;
        for (int k = 0; k < 4; k++) b_data[8*k +: 8] <= mem_b[b_addr[7:0] + 8'(k)];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Wait (bounded) for a fire on the main instance, check it, then step past it.
    task automatic wait_fire(input string tag, input logic [31:0] pc, input logic [2:0] len,
                             input logic [31:0] npc, input logic [7:0] op, input logic ill);
        int n;
        n = 0;
        #1;
        while (!(a_ivalid && a_ready) && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 64'(n < 40), 64'd1);
        check({tag, "_pc"},  64'(a_pc), 64'(pc));
        check({tag, "_len"}, 64'(a_len), 64'(len));
        check({tag, "_npc"}, 64'(a_npc), 64'(npc));
        check({tag, "_op"},  64'(a_instr[7:0]), 64'(op));
        check({tag, "_ill"}, 64'(a_ill), 64'(ill));
        tick();
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'h90;
            mem_b[i] = 8'h90;
        end
        // 90 | 01 00 | 83 00 00 | B8 00 00 00 00 | F4
        mem_a[1] = 8'h01; mem_a[2] = 8'h00; mem_a[3] = 8'h83; mem_a[4] = 8'h00; mem_a[5] = 8'h00;
        mem_a[6] = 8'hB8;
        for (int i = 7; i <= 10; i++) mem_a[i] = 8'h00;
        mem_a[11] = 8'hF4;
        // Jump target area: 83 55 66 | 12 | E9 01 02 03 04 | BF 00 00 00 00 | C0
        mem_a[8'h40] = 8'h83; mem_a[8'h41] = 8'h55; mem_a[8'h42] = 8'h66; mem_a[8'h43] = 8'h12;
        mem_a[8'h44] = 8'hE9; mem_a[8'h45] = 8'h01; mem_a[8'h46] = 8'h02; mem_a[8'h47] = 8'h03;
        mem_a[8'h48] = 8'h04; mem_a[8'h49] = 8'hBF;
        for (int i = 8'h4A; i <= 8'h4D; i++) mem_a[i] = 8'h00;
        mem_a[8'h4E] = 8'hC0;
        // Wrap image: B8 lands on queue index 6 of the 8-byte queue.
        mem_b[6] = 8'hB8; mem_b[7] = 8'h11; mem_b[8] = 8'h22; mem_b[9] = 8'h33; mem_b[10] = 8'h44;

        rst_n = 1'b0; is_jmp = 1'b0; is_halt = 1'b0; jmp_target = '0; a_ready = 1'b1;
        b_rst_n = 1'b0; b_jmp = 1'b0; b_halt = 1'b0; b_target = '0; b_ready = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_req",    64'(a_req), 64'd0);
        check("rst_valid",  64'(a_ivalid), 64'd0);
        check("rst_instr",  64'(a_instr), 64'd0);
        check("rst_len",    64'(a_len), 64'd1);
        check("rst_pc",     64'(a_pc), 64'd0);
        check("rst_npc",    64'(a_npc), 64'd0);
        check("rst_halted", 64'(a_halted), 64'd0);

        // 1. Stream decode
        rst_n = 1'b1;
        #1;
        check("start_req",  64'(a_req), 64'd1);
        check("start_addr", 64'(a_addr), 64'd0);
        wait_fire("s0", 32'd0, 3'd1, 32'd1, 8'h90, 1'b0);
        wait_fire("s1", 32'd1, 3'd2, 32'd3, 8'h01, 1'b0);

        // 2. Backpressure at pc=3
        a_ready = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            check("bp_valid", 64'(a_ivalid), 64'd1);
            check("bp_instr", 64'(a_instr), 64'h00_0000_0083);
            check("bp_pc",    64'(a_pc), 64'd3);
            tick();
        end
        check("bp_req_drop", 64'(a_req), 64'd0);
        a_ready = 1'b1;
        wait_fire("s2", 32'd3, 3'd3, 32'd6, 8'h83, 1'b0);
        wait_fire("s3", 32'd6, 3'd5, 32'd11, 8'hB8, 1'b0);

        // 4. Halt on F4
        wait_fire("halt_op", 32'd11, 3'd1, 32'd12, 8'hF4, 1'b0);
        check("halted_set", 64'(a_halted), 64'd1);
        for (int i = 0; i < 10; i++) begin
            check("halt_req",   64'(a_req), 64'd0);
            check("halt_valid", 64'(a_ivalid), 64'd0);
            tick();
        end
        is_jmp = 1'b1; jmp_target = 32'd0;
        #1;
        check("hj_T_req", 64'(a_req), 64'd0);
        tick();
        is_jmp = 1'b0;
        #1;
        check("hj_T1_halted", 64'(a_halted), 64'd0);
        check("hj_T1_req",    64'(a_req), 64'd1);
        check("hj_T1_addr",   64'(a_addr), 64'd0);
        tick();
        check("hj_T2_valid", 64'(a_ivalid), 64'd0);
        tick();
        check("hj_T3_valid", 64'(a_ivalid), 64'd1);
        wait_fire("restart", 32'd0, 3'd1, 32'd1, 8'h90, 1'b0);

        // 3. Jump with a response in flight, together with is_halt
        n = 0;
        while (!a_req && n < 20) begin
            tick();
            n++;
        end
        check("j_req_seen", 64'(n < 20), 64'd1);
        tick();
        is_jmp = 1'b1; jmp_target = 32'h40; is_halt = 1'b1;
        #1;
        check("j_T_req", 64'(a_req), 64'd0);
        tick();
        is_jmp = 1'b0; is_halt = 1'b0;
        #1;
        check("j_T1_halted", 64'(a_halted), 64'd0);
        check("j_T1_req",    64'(a_req), 64'd1);
        check("j_T1_addr",   64'(a_addr), 64'h40);
        check("j_T1_valid",  64'(a_ivalid), 64'd0);
        tick();
        check("j_T2_valid", 64'(a_ivalid), 64'd0);
        tick();
        check("j_T3_valid", 64'(a_ivalid), 64'd1);
        check("j_T3_instr", 64'(a_instr), 64'h00_0066_5583);
        wait_fire("j0", 32'h40, 3'd3, 32'h43, 8'h83, 1'b0);
        wait_fire("ill12", 32'h43, 3'd1, 32'h44, 8'h12, 1'b1);
        #1;
        check("e9_instr", 64'(a_instr), 64'h04_0302_01E9);
        wait_fire("e9", 32'h44, 3'd5, 32'h49, 8'hE9, 1'b0);
        wait_fire("bf", 32'h49, 3'd5, 32'h4E, 8'hBF, 1'b0);
        wait_fire("illc0", 32'h4E, 3'd1, 32'h4F, 8'hC0, 1'b1);

        // 6. Reset while a request is in flight
        n = 0;
        while (!a_req && n < 20) begin
            tick();
            n++;
        end
        check("r_req_seen", 64'(n < 20), 64'd1);
        tick();
        rst_n = 1'b0;
        tick();
        check("mr_req",    64'(a_req), 64'd0);
        check("mr_valid",  64'(a_ivalid), 64'd0);
        check("mr_instr",  64'(a_instr), 64'd0);
        check("mr_len",    64'(a_len), 64'd1);
        check("mr_pc",     64'(a_pc), 64'd0);
        check("mr_npc",    64'(a_npc), 64'd0);
        check("mr_halted", 64'(a_halted), 64'd0);
        rst_n = 1'b1;
        #1;
        check("mr_restart_req",  64'(a_req), 64'd1);
        check("mr_restart_addr", 64'(a_addr), 64'd0);
        wait_fire("mr0", 32'd0, 3'd1, 32'd1, 8'h90, 1'b0);
        wait_fire("mr1", 32'd1, 3'd2, 32'd3, 8'h01, 1'b0);

        // 5. Wrap: instruction straddling queue index 7 -> 0
        b_rst_n = 1'b1;
        n = 0;
        #1;
        while (!(b_ivalid && b_pc == 32'd6) && n < 60) begin
            tick();
            n++;
        end
        check("wrap_timeout", 64'(n < 60), 64'd1);
        check("wrap_instr",   64'(b_instr), 64'h44_3322_11B8);
        check("wrap_len",     64'(b_len), 64'd5);
        check("wrap_npc",     64'(b_npc), 64'd11);
        check("wrap_ill",     64'(b_ill), 64'd0);
        check("wrap_halted",  64'(b_halted), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
